uart_tx_buf: RTL and testbench

//  UART transmit side for the BASYS3 link; the counterpart of the RXBUF receive path.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 59 +++++
 rtl/uart_tx_buf.sv | 120 ++++++++++++
 tb/tb_uart_tx_buf.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame builder for the UART transmit path.
// Build option: UART_TX_PARITY_EN puts odd parity in the parity slot; otherwise that slot is a second stop bit.
package uart_pkg;

  localparam int UART_DATA_BIT = 8;
  localparam int FRAME_BITS    = UART_DATA_BIT + 3;

  typedef enum logic [0:0] {TX_IDLE, TX_SEND} tx_state_t;

  // Frame as shifted out LSB first: start(0), data, parity slot, stop(1).
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [UART_DATA_BIT-1:0] data);
    logic par;
`ifdef UART_TX_PARITY_EN
    par = ~^data;
`else
    par = 1'b1;
`endif
    return {1'b1, par, data, 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter; DEPTH must be a power of 2.
module uart_tx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wr_data,
  output logic [DW-1:0]          rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rptr_q];

  // full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO plus 11-bit frame serialiser, LSB first, idle-high line.
// Build option: UART_TX_PARITY_EN (see uart_pkg) selects odd parity vs. a second stop bit.
module uart_tx_buf import uart_pkg::*; #(
  parameter int DATA_BIT   = UART_DATA_BIT,
  parameter int ITEM_COUNT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 clkdiv,
  input  logic [DATA_BIT-1:0]         wr_data,
  input  logic                        wr_en,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(ITEM_COUNT):0] count,
  output logic                        busy,
  output logic                        ovf,
  output logic                        done,
  output logic                        tx
);

  localparam int BCW = $clog2(FRAME_BITS + 1);

  tx_state_t             state_q, state_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [15:0]           div_q, div_d, cyc_q, cyc_d;
  logic [BCW-1:0]        bitcnt_q, bitcnt_d;
  logic                  tx_q, tx_d, done_q, done_d, ovf_q, ovf_d;
  logic                  pop, bit_end, last_bit;
  logic [DATA_BIT-1:0]   head;

  uart_tx_fifo #(.DW(DATA_BIT), .DEPTH(ITEM_COUNT)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign bit_end  = (cyc_q == div_q);
  assign last_bit = bit_end && (bitcnt_q == BCW'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE: if (!empty)  state_d = TX_SEND;
      TX_SEND: if (last_bit) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  // div_q is captured at load so clkdiv edits only affect the next frame.
  always_comb begin
    pop      = 1'b0;
    sh_d     = sh_q;
    div_d    = div_q;
    cyc_d    = cyc_q;
    bitcnt_d = bitcnt_q;
    done_d   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          sh_d     = build_frame(head);
          div_d    = clkdiv;
          cyc_d    = '0;
          bitcnt_d = '0;
        end
      end
      TX_SEND: begin
        if (bit_end) begin
          cyc_d    = '0;
          sh_d     = {1'b1, sh_q[FRAME_BITS-1:1]};
          bitcnt_d = bitcnt_q + BCW'(1);
          done_d   = last_bit;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: ;
    endcase
    // tx_q mirrors the bit that will be current next cycle, so the line is glitch-free.
    tx_d  = (state_d == TX_SEND) ? sh_d[0] : 1'b1;
    ovf_d = wr_en && full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q     <= '1;
      div_q    <= '0;
      cyc_q    <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      div_q    <= div_d;
      cyc_q    <= cyc_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q != TX_IDLE);
  assign tx   = tx_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: a queue-based frame model checks every cycle, plus directed scenarios.
module tb_uart_tx_buf;

  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR01 = 1'b0;
  localparam bit PAR00 = 1'b1;
`else
  localparam bit PAR01 = 1'b1;
  localparam bit PAR00 = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst, wr_en;
  logic [15:0] clkdiv;
  logic [7:0]  wr_data;
  logic        full, empty, busy, ovf, done, tx;
  logic [2:0]  count;

  always #5 clk = ~clk;

  uart_tx_buf #(.DATA_BIT(8), .ITEM_COUNT(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .clkdiv  (clkdiv),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .busy    (busy),
    .ovf     (ovf),
    .done    (done),
    .tx      (tx)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int dut_dones = 0;

  // Model: bytes waiting, plus the frame currently on the line.
  logic [7:0] fifo_q[$];
  bit         m_active = 1'b0;
  bit         exp_done = 1'b0;
  bit         exp_ovf  = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_div = 0;
  int         m_cyc = 0;

  function automatic bit frame_bit(logic [7:0] b, int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ~(^b);
`else
    if (i == 9) return 1'b1;
`endif
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; model advances across the edge, then every output is compared.
  task automatic tick();
    bit         was_rst, do_pop, do_push, ovf_n;
    int         nd;
    logic [7:0] wd;
    was_rst = rst;
    nd      = clkdiv;
    wd      = wr_data;
    do_pop  = !m_active && fifo_q.size() > 0;
    do_push = wr_en && fifo_q.size() < DEPTH;
    ovf_n   = wr_en && fifo_q.size() == DEPTH;
    @(posedge clk);
    #1;
    if (was_rst) begin
      fifo_q.delete();
      m_active = 1'b0;
      exp_done = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      exp_done = 1'b0;
      exp_ovf  = ovf_n;
      if (m_active) begin
        m_cyc++;
        if (m_cyc == 11 * (m_div + 1)) begin
          m_active = 1'b0;
          exp_done = 1'b1;
        end
      end else if (do_pop) begin
        m_byte   = fifo_q.pop_front();
        m_div    = nd;
        m_cyc    = 0;
        m_active = 1'b1;
      end
      if (do_push) fifo_q.push_back(wd);
    end
    chk("tx",    tx,    m_active ? frame_bit(m_byte, m_cyc / (m_div + 1)) : 1'b1);
    chk("done",  done,  exp_done);
    chk("ovf",   ovf,   exp_ovf);
    chk("busy",  busy,  m_active);
    chk("count", count, fifo_q.size());
    chk("full",  full,  fifo_q.size() == DEPTH);
    chk("empty", empty, fifo_q.size() == 0);
    if (done === 1'b1) dut_dones++;
  endtask

  task automatic push(logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain(int max);
    int n = 0;
    while ((m_active || fifo_q.size() > 0 || exp_done) && n < max) begin
      tick();
      n++;
    end
    chk("drain_in_time", n < max, 1);
    tick();
  endtask

  task automatic wait_done(int max, output int n);
    n = 0;
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int n, d0;
    logic [7:0] b;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clkdiv = 16'd3;
    tick();
    tick();
    chk("rst_tx", tx, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    rst = 1'b0;
    tick();

    // 1: latency and frame length with clkdiv=3
    push(8'hA5);
    chk("t1_pending", count, 1);
    chk("t1_still_high", tx, 1);
    tick();
    chk("t1_fall", tx, 0);
    wait_done(100, n);
    chk("t1_done_at", n, 44);
    drain(200);

    // 2: parity slot
    push(8'h01);
    tick();
    repeat (37) tick();
    chk("t2_par01", tx, PAR01);
    drain(200);
    push(8'h00);
    tick();
    repeat (37) tick();
    chk("t2_par00", tx, PAR00);
    drain(200);

    // 3: overflow while busy
    d0 = dut_dones;
    push(8'($urandom));
    tick();
    for (int k = 0; k < 4; k++) begin
      push(8'($urandom));
      chk("t3_count", count, k + 1);
    end
    chk("t3_full", full, 1);
    push(8'($urandom));
    chk("t3_ovf", ovf, 1);
    chk("t3_count_held", count, 4);
    tick();
    chk("t3_ovf_clear", ovf, 0);
    drain(600);
    chk("t3_frames", dut_dones - d0, 5);

    // 4: reset during bit 5
    d0 = dut_dones;
    push(8'($urandom));
    tick();
    repeat (21) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_tx", tx, 1);
    chk("t4_count", count, 0);
    chk("t4_busy", busy, 0);
    repeat (50) tick();
    chk("t4_no_done", dut_dones - d0, 0);
    push(8'($urandom));
    drain(200);
    chk("t4_clean_frame", dut_dones - d0, 1);

    // 5: clkdiv change mid-frame
    push(8'($urandom));
    b = 8'($urandom) | 8'h01;
    push(b);
    repeat (10) tick();
    clkdiv = 16'd7;
    wait_done(100, n);
    chk("t5_old_div", n + 10, 44);
    tick();
    repeat (7) tick();
    chk("t5_startbit_8", tx, 0);
    tick();
    chk("t5_bit0", tx, 1);
    drain(300);

    // 6: back-to-back frames
    clkdiv = 16'($urandom_range(0, 2));
    d0 = dut_dones;
    push(8'($urandom));
    push(8'($urandom));
    push(8'($urandom));
    wait_done(200, n);
    chk("t6_gap_hi", tx, 1);
    tick();
    chk("t6_restart", tx, 0);
    wait_done(200, n);
    chk("t6_gap_hi2", tx, 1);
    tick();
    chk("t6_restart2", tx, 0);
    drain(200);
    chk("t6_frames", dut_dones - d0, 3);

    // clkdiv=0 gives 1-cycle bits
    clkdiv = 16'd0;
    push(8'($urandom));
    push(8'($urandom));
    drain(100);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
      end else begin
        wr_en = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) clkdiv = 16'($urandom_range(0, 3));
      tick();
    end
    wr_en = 1'b0;
    drain(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
